bitcell_array: RTL and testbench

BITCELL_ARRAY -- requirements
Module: bitcell_array

---
 rtl/bitcell_pkg.sv | 22 ++
 rtl/bitcell_word.sv | 25 ++
 rtl/bitcell_array.sv | 134 +++++++++++++
 tb/tb_bitcell_array.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bitcell_pkg.sv
// bitcell_pkg: shared types and constants for the bitcell array.
//   state_e  : controller states (ST_INIT zero-sweep, ST_IDLE serving)
//   OP_*     : encoding of the r_w request field
//   PAR_W    : extra stored bits per word (1 when BITCELL_ARRAY_PARITY_EN
//              is defined, otherwise 0)
package bitcell_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

`ifdef BITCELL_ARRAY_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

endpackage

// File: rtl/bitcell_word.sv
// bitcell_word: one storage row of the bitcell array.
//   clk : clock
//   we  : write enable, row captures d on the rising edge
//   d   : row write data (data bits plus optional parity bit)
//   q   : row contents
// The row has no reset; its contents are defined only after the
// controller's zero-sweep has visited it.
module bitcell_word #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  always_ff @(posedge clk) begin
    if (we) q_r <= d;
  end

  assign q = q_r;

endmodule

// File: rtl/bitcell_array.sv
// bitcell_array: DEPTH x WIDTH word array with a zero-sweep after reset.
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   sel       : request valid
//   r_w       : 1 = write, 0 = read
//   addr      : word address
//   in        : write data
//   ready     : array accepts a request this cycle
//   out       : read data, holds the last read value
//   out_valid : one-cycle pulse, out updated
//   addr_err  : one-cycle pulse, accepted request addressed beyond DEPTH
//   par_err   : one-cycle pulse with out_valid, parity mismatch on read
// Build option: BITCELL_ARRAY_PARITY_EN adds one even-parity bit per word
// and enables par_err; without it par_err is tied low.
//
// state   | meaning
// --------+-------------------------------------------------------
// ST_INIT | zero-sweep, one word per cycle, requests ignored
// ST_IDLE | serving read/write requests
module bitcell_array
  import bitcell_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              r_w,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  in,
  output logic              ready,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid,
  output logic              addr_err,
  output logic              par_err
);

  localparam int CW = WIDTH + PAR_W;
  // one extra bit so that power-of-2 DEPTH is representable
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q;
  logic              init_last;
  logic              accept, addr_ok, wr_acc, rd_acc;
  logic [CW-1:0]     row_d;
  logic [DEPTH-1:0]  row_we;
  logic [CW-1:0]     row_q [DEPTH];
  logic [CW-1:0]     rd_row;
  logic [WIDTH-1:0]  out_q;
  logic              out_valid_q, addr_err_q;

  assign init_last = (init_cnt_q == ADDR_W'(DEPTH - 1));
  assign ready     = (state_q == ST_IDLE);
  assign accept    = sel & ready;
  assign addr_ok   = ({1'b0, addr} < DEPTH_EXT);
  assign wr_acc    = accept & (r_w == OP_WRITE) & addr_ok;
  assign rd_acc    = accept & (r_w == OP_READ) & addr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (init_last) state_d = ST_IDLE;
      ST_IDLE: state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  // The sweep shares the row write port: zero data while in ST_INIT.
  always_comb begin
    row_d = '0;
    if (state_q == ST_IDLE) begin
`ifdef BITCELL_ARRAY_PARITY_EN
      row_d = {^in, in};
`else
      row_d = in;
`endif
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign row_we[i] = ((state_q == ST_INIT) && (init_cnt_q == ADDR_W'(i))) ||
                       (wr_acc && (addr == ADDR_W'(i)));
    bitcell_word #(.W(CW)) u_word (
      .clk (clk),
      .we  (row_we[i]),
      .d   (row_d),
      .q   (row_q[i])
    );
  end

  // Only consumed when addr_ok, so out-of-range indexing is harmless.
  assign rd_row = row_q[addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt_q  <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      if (state_q == ST_INIT) init_cnt_q <= init_last ? '0 : init_cnt_q + 1'b1;
      out_valid_q <= rd_acc;
      addr_err_q  <= accept & ~addr_ok;
      if (rd_acc) out_q <= rd_row[WIDTH-1:0];
    end
  end

`ifdef BITCELL_ARRAY_PARITY_EN
  logic par_err_q;

  // Even parity over data plus stored bit must be zero for a clean word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= rd_acc & (^rd_row);
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_bitcell_array.sv
module tb_bitcell_array;

`ifdef BITCELL_ARRAY_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel, r_w;
  logic [3:0] addr;
  logic [7:0] in_d;

  logic       rdy16, ov16, ae16, pe16;
  logic [7:0] out16;
  logic       rdy12, ov12, ae12, pe12;
  logic [7:0] out12;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  bitcell_array #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .r_w(r_w), .addr(addr), .in(in_d),
    .ready(rdy16), .out(out16), .out_valid(ov16), .addr_err(ae16), .par_err(pe16)
  );

  bitcell_array #(.WIDTH(8), .DEPTH(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .r_w(r_w), .addr(addr), .in(in_d),
    .ready(rdy12), .out(out12), .out_valid(ov12), .addr_err(ae12), .par_err(pe12)
  );

  // Reference model: index 0 = DEPTH 16 instance, index 1 = DEPTH 12 instance.
  int         dep [2] = '{16, 12};
  logic [7:0] m_mem [2][16];
  bit         m_bad [2][16];
  int         m_init [2];
  logic [7:0] e_out [2];
  bit         e_ov [2], e_ae [2], e_pe [2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_init[k] = dep[k];
      e_out[k]  = 8'h00;
      e_ov[k]   = 1'b0;
      e_ae[k]   = 1'b0;
      e_pe[k]   = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < 2; k++) begin
      e_ov[k] = 1'b0;
      e_ae[k] = 1'b0;
      e_pe[k] = 1'b0;
      if (m_init[k] > 0) begin
        m_mem[k][dep[k] - m_init[k]] = 8'h00;
        m_bad[k][dep[k] - m_init[k]] = 1'b0;
        m_init[k]--;
      end else if (sel) begin
        if (int'(addr) < dep[k]) begin
          if (r_w) begin
            m_mem[k][addr] = in_d;
            m_bad[k][addr] = 1'b0;
          end else begin
            e_out[k] = m_mem[k][addr];
            e_ov[k]  = 1'b1;
            e_pe[k]  = PAR && m_bad[k][addr];
          end
        end else begin
          e_ae[k] = 1'b1;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, " out16"}, 32'(out16), 32'(e_out[0]));
    chk({tag, " ov16"},  32'(ov16),  32'(e_ov[0]));
    chk({tag, " ae16"},  32'(ae16),  32'(e_ae[0]));
    chk({tag, " pe16"},  32'(pe16),  32'(e_pe[0]));
    chk({tag, " out12"}, 32'(out12), 32'(e_out[1]));
    chk({tag, " ov12"},  32'(ov12),  32'(e_ov[1]));
    chk({tag, " ae12"},  32'(ae12),  32'(e_ae[1]));
    chk({tag, " pe12"},  32'(pe12),  32'(e_pe[1]));
  endtask

  task automatic chk_ready(input string tag);
    chk({tag, " rdy16"}, 32'(rdy16), 32'(m_init[0] == 0));
    chk({tag, " rdy12"}, 32'(rdy12), 32'(m_init[1] == 0));
  endtask

  // Called at a falling edge: check ready, drive, clock, check results.
  task automatic step(input string tag, input logic s, input logic rw,
                      input logic [3:0] a, input logic [7:0] d);
    chk_ready(tag);
    sel = s; r_w = rw; addr = a; in_d = d;
    @(posedge clk);
    model_edge();
    #1;
    chk_outs(tag);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; r_w = 1'b0; addr = '0; in_d = '0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) begin
        m_mem[k][i] = 8'hxx;
        m_bad[k][i] = 1'b0;
      end
    model_reset();
    #2;
    chk_outs("reset");
    chk_ready("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // INIT with writes requested every cycle: ignored while ready is low
    for (int i = 0; i < 16; i++)
      step("init_wr", 1'b1, 1'b1, 4'($urandom_range(0, 15)), 8'($urandom));

    // back-to-back reads of all addresses
    for (int i = 0; i < 16; i++) step("rd_all", 1'b1, 1'b0, 4'(i), 8'h00);

    // write then read same address, next cycle
    step("wr_a5", 1'b1, 1'b1, 4'd3, 8'hA5);
    step("rd_a5", 1'b1, 1'b0, 4'd3, 8'h00);
    step("idle",  1'b0, 1'b0, 4'd3, 8'h00);

    // out-of-range for the 12-word instance
    step("wr_13", 1'b1, 1'b1, 4'd13, 8'hFF);
    step("rd_3",  1'b1, 1'b0, 4'd3, 8'h00);
    step("rd_13", 1'b1, 1'b0, 4'd13, 8'h00);
    step("idle2", 1'b0, 1'b1, 4'd13, 8'h12);

    // randomized traffic
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 8'($urandom));

    // single stored-bit flip in word 5
    step("wr_5", 1'b1, 1'b1, 4'd5, 8'h3C);
    step("gap",  1'b0, 1'b0, 4'd0, 8'h00);
    dut.g_word[5].u_word.q_r[0] = ~dut.g_word[5].u_word.q_r[0];
    m_mem[0][5] = m_mem[0][5] ^ 8'h01;
    m_bad[0][5] = 1'b1;
    step("rd_flip5", 1'b1, 1'b0, 4'd5, 8'h00);
    step("rd_4",     1'b1, 1'b0, 4'd4, 8'h00);
    step("rewr_5",   1'b1, 1'b1, 4'd5, 8'h81);
    step("rd_5",     1'b1, 1'b0, 4'd5, 8'h00);

    // reset asserted in the same cycle as a read request
    step("pre_rst", 1'b1, 1'b1, 4'd7, 8'h5A);
    sel = 1'b1; r_w = 1'b0; addr = 4'd7;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_outs("rst_async");
    chk_ready("rst_async");
    @(posedge clk);
    #1;
    chk_outs("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // reset mid-INIT: sweep must restart from address 0
    for (int i = 0; i < 5; i++) step("init_a", 1'b1, 1'b1, 4'(i), 8'hEE);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_outs("rst_init");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++)
      step("init_b", 1'b1, 1'b1, 4'($urandom_range(0, 15)), 8'($urandom));
    for (int i = 0; i < 16; i++) step("rd_all2", 1'b1, 1'b0, 4'(i), 8'h00);
    step("end", 1'b0, 1'b0, 4'd0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
